// File: rtl/reg_cmd_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_cmd_pkg                                                          |
// | Shared types, constants and helpers for the register command parser. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_DATA   = 3'd1,
    W_COMMIT = 3'd2,
    R_ISSUE  = 3'd3,
    R_WAIT   = 3'd4,
    R_SEND   = 3'd5
  } state_t;

  localparam int         OP_BIT   = 7;
  localparam logic       OP_WRITE = 1'b1;
  localparam logic [7:0] ERR_BYTE = 8'hFF;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  // Header address is 7 bits; anything at or above the register count is rejected.
  function automatic logic addr_in_range(input logic [6:0] addr, input int depth);
    return ({25'd0, addr} < 32'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_cmd_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_cmd_parser_if                                                    |
// | Byte streams plus register-file read/write ports of the parser.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface reg_cmd_parser_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
);
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             o_rx_ready;
  logic             o_w_en;
  logic [AW-1:0]    o_w_addr;
  logic [WIDTH-1:0] o_w_value;
  logic             o_r_en;
  logic [AW-1:0]    o_r_addr;
  logic [WIDTH-1:0] i_r_value;
  logic             i_r_valid;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_ready;
  logic             o_err;

  modport slave (
    input  i_rx_data, i_rx_valid, i_r_value, i_r_valid, i_tx_ready,
    output o_rx_ready, o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr,
           o_tx_data, o_tx_valid, o_err
  );

  modport master (
    output i_rx_data, i_rx_valid, i_r_value, i_r_valid, i_tx_ready,
    input  o_rx_ready, o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr,
           o_tx_data, o_tx_valid, o_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_parser_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_cmd_serializer                                                   |
// | Loads a word and emits it MSB-first as bytes under valid/ready.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
import reg_cmd_pkg::*;

module reg_cmd_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_ready,
  output logic             o_done
);
  localparam int NB = nbytes(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_cnt;
  logic             r_valid;
  logic             w_fire;
  logic             w_last;

  assign w_fire     = r_valid && i_tx_ready;
  assign w_last     = (r_cnt == 4'(NB - 1));
  assign o_done     = w_fire && w_last;
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_shift[WIDTH-1 -: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_last) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= r_shift << 8;
        r_cnt   <= r_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_cmd_parser                                                       |
// | Byte-stream command decoder driving a register file's r/w ports.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
import reg_cmd_pkg::*;

module reg_cmd_parser #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 4
) (
  input logic            clk,
  input logic            reset,
  reg_cmd_parser_if.slave bus
);
  localparam int NB = nbytes(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic             r_oor;
  logic [3:0]       r_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic [WIDTH-1:0] r_wdata;
  logic             r_w_en;
  logic [AW-1:0]    r_w_addr;
  logic [WIDTH-1:0] r_w_value;
  logic             r_r_en;
  logic [AW-1:0]    r_r_addr;
  logic             r_err;

  logic             w_rx_ready;
  logic             w_rx_fire;
  logic             w_hdr_oor;
  logic [WIDTH-1:0] w_wdata_next;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_ser_done;
  logic             w_timeout;

  assign w_rx_ready   = (r_state == IDLE) || (r_state == W_DATA);
  assign w_rx_fire    = w_rx_ready && bus.i_rx_valid;
  assign w_hdr_oor    = !addr_in_range(bus.i_rx_data[6:0], DEPTH);
  assign w_wdata_next = (r_wdata << 8) | WIDTH'(bus.i_rx_data);
  assign w_timeout    = (r_to_cnt == TW'(TIMEOUT - 1));

  // Serializer load happens on the same edge the FSM enters R_SEND.
  always_comb begin
    w_load      = 1'b0;
    w_load_word = '0;
    case (r_state)
      R_ISSUE: begin
        if (r_oor) begin
          w_load      = 1'b1;
          w_load_word = {NB{ERR_BYTE}};
        end
      end
      R_WAIT: begin
        if (bus.i_r_valid) begin
          w_load      = 1'b1;
          w_load_word = bus.i_r_value;
        end else if (w_timeout) begin
          w_load      = 1'b1;
          w_load_word = {NB{ERR_BYTE}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_oor     <= 1'b0;
      r_cnt     <= '0;
      r_to_cnt  <= '0;
      r_wdata   <= '0;
      r_w_en    <= 1'b0;
      r_w_addr  <= '0;
      r_w_value <= '0;
      r_r_en    <= 1'b0;
      r_r_addr  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      r_r_en <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rx_fire) begin
            r_addr <= bus.i_rx_data[AW-1:0];
            r_oor  <= w_hdr_oor;
            if (bus.i_rx_data[OP_BIT] == OP_WRITE) begin
              r_state <= W_DATA;
              r_cnt   <= '0;
            end else begin
              // Read strobe is issued from here so it is visible during R_ISSUE.
              r_state <= R_ISSUE;
              if (!w_hdr_oor) begin
                r_r_en   <= 1'b1;
                r_r_addr <= bus.i_rx_data[AW-1:0];
              end
            end
          end
        end
        W_DATA: begin
          if (w_rx_fire) begin
            r_wdata <= w_wdata_next;
            if (r_cnt == 4'(NB - 1)) begin
              r_state <= W_COMMIT;
              if (r_oor) begin
                r_err <= 1'b1;
              end else begin
                r_w_en    <= 1'b1;
                r_w_addr  <= r_addr;
                r_w_value <= w_wdata_next;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        W_COMMIT: r_state <= IDLE;
        R_ISSUE: begin
          if (r_oor) begin
            r_err   <= 1'b1;
            r_state <= R_SEND;
          end else begin
            r_to_cnt <= '0;
            r_state  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (bus.i_r_valid) begin
            r_state <= R_SEND;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= R_SEND;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        R_SEND: begin
          if (w_ser_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  reg_cmd_serializer #(
    .WIDTH(WIDTH)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_word     (w_load_word),
    .o_tx_valid (bus.o_tx_valid),
    .o_tx_data  (bus.o_tx_data),
    .i_tx_ready (bus.i_tx_ready),
    .o_done     (w_ser_done)
  );

  assign bus.o_rx_ready = w_rx_ready;
  assign bus.o_w_en     = r_w_en;
  assign bus.o_w_addr   = r_w_addr;
  assign bus.o_w_value  = r_w_value;
  assign bus.o_r_en     = r_r_en;
  assign bus.o_r_addr   = r_r_addr;
  assign bus.o_err      = r_err;

endmodule
`default_nettype wire
